// File: rtl/pwm_button_conditioner.sv
// -----------------------------------------------------------------------------
// pwm_button_conditioner
//
// Turns two raw, bouncing, asynchronous push buttons into clean one-cycle
// increment/decrement requests for the downstream PWM generator.
// Per button: two-flop synchronizer, counter-based debounce, and a press pulse
// registered on the same edge the debounced level rises.
//
// Optional feature (macro PWM_BTN_AUTO_REPEAT_EN):
//   When defined, a button held alone repeats its pulse HOLD_CYCLES after the
//   press (or after the other button releases), then every REPEAT_CYCLES.
//   When undefined, exactly one pulse is produced per debounced press.
//
// Ports:
//   i_clk           system clock (100 MHz)
//   i_rst_n         asynchronous active-low reset
//   i_increase_btn  raw increase button, asynchronous, active-high
//   i_decrease_btn  raw decrease button, asynchronous, active-high
//   o_inc_pulse     one-cycle increment request
//   o_dec_pulse     one-cycle decrement request
//   o_inc_level     debounced increase-button level
//   o_dec_level     debounced decrease-button level
// -----------------------------------------------------------------------------
module pwm_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 20000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_increase_btn,
  input  logic i_decrease_btn,
  output logic o_inc_pulse,
  output logic o_dec_pulse,
  output logic o_inc_level,
  output logic o_dec_level
);

  localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 = increase button, bit 1 = decrease button.
  logic [1:0] w_raw;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_level;
  logic [1:0] r_pulse;
  logic [1:0] w_flip;
  logic [1:0] w_level_nxt;
  logic [1:0] w_press;
  logic [1:0] w_rpt;

  assign w_raw = {i_decrease_btn, i_increase_btn};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  genvar b;
  generate
    for (b = 0; b < 2; b++) begin : g_btn
      logic [DB_W-1:0] r_db_cnt;

      // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
      assign w_flip[b] = (r_sync2[b] != r_level[b]) && (r_db_cnt == DB_LAST);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_db_cnt <= '0;
        end else if ((r_sync2[b] == r_level[b]) || w_flip[b]) begin
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end

      // A press counts only if the other button is low both before and after
      // this edge: covers simultaneous rise and other-already-held cases.
      assign w_press[b] = w_flip[b] & w_level_nxt[b] & ~r_level[1-b] & ~w_level_nxt[1-b];

`ifdef PWM_BTN_AUTO_REPEAT_EN
      localparam int              HR_MAX   = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
      localparam int              HOLD_W   = (HR_MAX > 1) ? $clog2(HR_MAX) : 1;
      localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
      localparam logic [HOLD_W-1:0] RPT_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

      logic              r_hold_cnt_dummy_unused;
      logic [HOLD_W-1:0] r_hold_cnt;
      logic              r_rpt_phase;
      logic              w_hold_clr;
      logic [HOLD_W-1:0] w_hold_last;

      assign r_hold_cnt_dummy_unused = 1'b0;

      // Own level low or both held: timing restarts from zero, no pulse.
      assign w_hold_clr  = ~r_level[b] | r_level[1-b];
      // First interval is the hold time, later ones the repeat period.
      assign w_hold_last = r_rpt_phase ? RPT_LAST : HOLD_LAST;
      assign w_rpt[b]    = ~w_hold_clr & (r_hold_cnt == w_hold_last);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_hold_cnt  <= '0;
          r_rpt_phase <= 1'b0;
        end else if (w_hold_clr) begin
          r_hold_cnt  <= '0;
          r_rpt_phase <= 1'b0;
        end else if (w_rpt[b]) begin
          r_hold_cnt  <= '0;
          r_rpt_phase <= 1'b1;
        end else begin
          r_hold_cnt  <= r_hold_cnt + 1'b1;
        end
      end
`endif
    end
  endgenerate

`ifndef PWM_BTN_AUTO_REPEAT_EN
  assign w_rpt = '0;
`endif

  assign w_level_nxt = r_level ^ w_flip;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level <= '0;
      r_pulse <= '0;
    end else begin
      r_level <= w_level_nxt;
      r_pulse <= w_press | w_rpt;
    end
  end

  assign o_inc_level = r_level[0];
  assign o_dec_level = r_level[1];
  assign o_inc_pulse = r_pulse[0];
  assign o_dec_pulse = r_pulse[1];

endmodule

// File: tb/tb_pwm_button_conditioner.sv
module tb_pwm_button_conditioner;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;
  localparam int TMAX = 20000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inc_btn = 1'b0;
  logic dec_btn = 1'b0;
  logic inc_pulse, dec_pulse, inc_level, dec_level;

  always #5 clk = ~clk;

  pwm_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_increase_btn(inc_btn),
    .i_decrease_btn(dec_btn),
    .o_inc_pulse   (inc_pulse),
    .o_dec_pulse   (dec_pulse),
    .o_inc_level   (inc_level),
    .o_dec_level   (dec_level)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: sync trace per button, level decided by a window rule,
  // repeat timing by elapsed-time arithmetic from an anchor edge.
  bit m_sy1 [2];
  bit m_sy2 [2];
  bit m_lvl [2];
  bit m_pul [2];
  bit trace [2][TMAX];
  int m_t;
  int m_last_flip [2];
  int m_anchor [2];
  bit prev_inc, prev_dec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_sy1[b] = 0; m_sy2[b] = 0; m_lvl[b] = 0; m_pul[b] = 0;
      m_last_flip[b] = -1; m_anchor[b] = 0;
    end
    m_t = 0;
    prev_inc = 0; prev_dec = 0;
  endtask

  task automatic model_edge();
    bit raw [2];
    bit flip [2];
    bit nl [2];
    int o, e;
    raw[0] = inc_btn;
    raw[1] = dec_btn;
    for (int b = 0; b < 2; b++) begin
      trace[b][m_t] = m_sy2[b];
      m_sy2[b] = m_sy1[b];
      m_sy1[b] = raw[b];
    end
    for (int b = 0; b < 2; b++) begin
      // Last D samples since the previous flip must all differ from level.
      flip[b] = (m_t - m_last_flip[b] >= D);
      if (flip[b])
        for (int k = 0; k < D; k++)
          if (trace[b][m_t-k] == m_lvl[b]) flip[b] = 0;
      nl[b] = flip[b] ? !m_lvl[b] : m_lvl[b];
    end
    for (int b = 0; b < 2; b++) begin
      o = 1 - b;
      m_pul[b] = flip[b] && nl[b] && !m_lvl[o] && !nl[o];
`ifdef PWM_BTN_AUTO_REPEAT_EN
      if (!m_lvl[b] || m_lvl[o]) m_anchor[b] = m_t;
      else begin
        e = m_t - m_anchor[b];
        if (e == H || (e > H && ((e - H) % R) == 0)) m_pul[b] = 1;
      end
`endif
    end
    for (int b = 0; b < 2; b++) begin
      m_lvl[b] = nl[b];
      if (flip[b]) m_last_flip[b] = m_t;
    end
    m_t++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("inc_level", inc_level, m_lvl[0]);
    chk("dec_level", dec_level, m_lvl[1]);
    chk("inc_pulse", inc_pulse, m_pul[0]);
    chk("dec_pulse", dec_pulse, m_pul[1]);
    chk("pulse_exclusive", inc_pulse & dec_pulse, 0);
    chk("inc_width", prev_inc & inc_pulse, 0);
    chk("dec_width", prev_dec & dec_pulse, 0);
    prev_inc = inc_pulse;
    prev_dec = dec_pulse;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int pcnt, dcnt, pedge, fall, hcnt, found, ocnt;
    int offs [8];
    int rem [2];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inc_level", inc_level, 0);
    chk("rst_dec_level", dec_level, 0);
    chk("rst_inc_pulse", inc_pulse, 0);
    chk("rst_dec_pulse", dec_pulse, 0);
    #4 rst_n = 1'b1;
    model_reset();

    // 1. Clean press and release
    inc_btn = 1; pcnt = 0; dcnt = 0; pedge = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (inc_pulse) begin pcnt++; pedge = i; end
      if (dec_pulse) dcnt++;
    end
    chk("s1_pulse_edge", pedge, 5);
    chk("s1_pulse_cnt", pcnt, 1);
    chk("s1_dec_cnt", dcnt, 0);
    chk("s1_level_high", inc_level, 1);
    inc_btn = 0; fall = -1; pcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (!inc_level && fall < 0) fall = i;
      if (inc_pulse) pcnt++;
    end
    chk("s1_fall_edge", fall, 5);
    chk("s1_release_pulse", pcnt, 0);

    // 2. Bounce rejection then steady press
    hcnt = 0; pcnt = 0;
    for (int i = 0; i < 40; i++) begin
      inc_btn = ((i % 4) < 3);
      step();
      if (inc_level) hcnt++;
      if (inc_pulse) pcnt++;
    end
    inc_btn = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (inc_level) hcnt++;
      if (inc_pulse) pcnt++;
    end
    chk("s2_bounce_level", hcnt, 0);
    chk("s2_bounce_pulse", pcnt, 0);
    inc_btn = 1; pcnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (inc_pulse) pcnt++;
    end
    chk("s2_steady_pulse", pcnt, 1);
    inc_btn = 0;
    run(12);

    // 3. Simultaneous press, then release decrease only
    inc_btn = 1; dec_btn = 1; pcnt = 0; dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (inc_pulse) pcnt++;
      if (dec_pulse) dcnt++;
    end
    chk("s3_inc_pulse", pcnt, 0);
    chk("s3_dec_pulse", dcnt, 0);
    chk("s3_inc_level", inc_level, 1);
    chk("s3_dec_level", dec_level, 1);
    dec_btn = 0; pcnt = 0; dcnt = 0; pedge = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (inc_pulse) begin pcnt++; pedge = i; end
      if (dec_pulse) dcnt++;
    end
    chk("s3_rel_dec_pulse", dcnt, 0);
`ifdef PWM_BTN_AUTO_REPEAT_EN
    chk("s3_rel_inc_pulse", pcnt, 1);
    chk("s3_rel_inc_edge", pedge, 25);
`else
    chk("s3_rel_inc_pulse", pcnt, 0);
`endif
    inc_btn = 0;
    run(12);

    // 4. Asynchronous reset mid-hold
    inc_btn = 1;
    run(12);
    #2 rst_n = 1'b0;
    #1;
    chk("s4_rst_inc_level", inc_level, 0);
    chk("s4_rst_dec_level", dec_level, 0);
    chk("s4_rst_inc_pulse", inc_pulse, 0);
    chk("s4_rst_dec_pulse", dec_pulse, 0);
    #2 rst_n = 1'b1;
    model_reset();
    pcnt = 0; pedge = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (inc_pulse) begin pcnt++; pedge = i; end
    end
    chk("s4_repress_edge", pedge, 5);
    chk("s4_repress_cnt", pcnt, 1);
    inc_btn = 0;
    run(12);

    // 5. Long hold after press pulse
    inc_btn = 1; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (inc_pulse) found = 1;
    end
    chk("s5_press_found", found, 1);
    ocnt = 0;
    for (int j = 1; j < 60; j++) begin
      step();
      if (inc_pulse) begin
        if (ocnt < 8) offs[ocnt] = j;
        ocnt++;
      end
    end
`ifdef PWM_BTN_AUTO_REPEAT_EN
    chk("s5_repeat_cnt", ocnt, 5);
    for (int k = 0; k < 5 && k < ocnt; k++)
      chk("s5_repeat_offset", offs[k], (k == 0) ? H : H + k * R);
`else
    chk("s5_repeat_cnt", ocnt, 0);
`endif
    inc_btn = 0;
    run(12);

    // 6. Random stimulus against the model
    rem[0] = 0; rem[1] = 0;
    for (int i = 0; i < 10000; i++) begin
      for (int b = 0; b < 2; b++) begin
        if (rem[b] == 0) begin
          rem[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
          if (b == 0) inc_btn = 1'($urandom_range(0, 1));
          else        dec_btn = 1'($urandom_range(0, 1));
        end
        rem[b]--;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_button_conditioner.md
Name: pwm_button_conditioner

Overview:
Front-end stage directly upstream of pwm_generator; it turns raw, bouncing, asynchronous push-button inputs into clean single-cycle increment/decrement requests.
- Per button: two-flop synchronizer, counter-based debounce, rising-edge pulse generation.
- Optional hold-to-repeat.
- inc_pulse/dec_pulse drive pwm_generator increase_duty/decrease_duty directly.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive clk cycles synchronized input must differ from debounced level before level flips (10 ms at 100 MHz); legal >= 2
HOLD_CYCLES, 50000000, cycles a button must stay debounced-high after its press pulse before first repeat pulse; legal >= 2
REPEAT_CYCLES, 20000000, cycles between successive repeat pulses while held; legal >= 2

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  reset; asynchronous, active-low
increase_btn  input  1  raw increase button, asynchronous to clk, active-high
decrease_btn  input  1  raw decrease button, asynchronous to clk, active-high
inc_pulse  output  1  one-cycle increment request
dec_pulse  output  1  one-cycle decrement request
inc_level  output  1  debounced increase-button level
dec_level  output  1  debounced decrease-button level

Behaviour:
- Reset: rst_n low asynchronously clears all state: synchronizers, debounce counters, hold/repeat counters, all four outputs = 0. Deassertion is sampled by clk; first active edge is the one after rst_n rises.
- Reset mid-debounce or mid-hold: everything clears. A button still held after reset must re-debounce to high and then produces a normal press pulse.
- Synchronizer: 2 flops per button. All logic below uses only the second flop output (sync).
- Debounce (per button):
  - sync != level: counter increments.
  - Counter reaches DEBOUNCE_CYCLES-1 while sync still differs: level flips and counter clears.
  - sync == level on any cycle: counter clears. Any glitch shorter than DEBOUNCE_CYCLES is rejected.
  - Counter width: $clog2(DEBOUNCE_CYCLES).
- Latency: raw input held stable from edge 0 → level (and press pulse) visible after edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges of total latency. Release has identical latency.
- Press pulse: on the cycle a level rises, the matching pulse is high for exactly 1 cycle, registered together with level. Level falling never produces a pulse.
- Simultaneous events:
  - Both levels rise on the same edge: no pulse on either.
  - One level rises while the other is already high: no pulse.
  - inc_pulse and dec_pulse are never high in the same cycle. This is an invariant.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
Macro: PWM_BTN_AUTO_REPEAT_EN

Defined:
- Per-button hold counter of width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)); clears on press pulse.
- While own level high and other level low, counter increments.
- First repeat pulse occurs HOLD_CYCLES cycles after the press pulse; further repeat pulses follow every REPEAT_CYCLES cycles.
- Counter clears, with no pulse, whenever own level is low or both levels are high.
- When the other button releases while own level is still high: no immediate pulse; hold timing restarts, so the first repeat comes HOLD_CYCLES cycles after the other level falls.

Not defined:
- Hold counters and repeat logic are absent.
- Exactly one pulse per debounced press.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
1. Clean press: increase_btn 0→1 at edge 0, held 10 cycles → inc_level=1 and inc_pulse=1 after edge 5 only; dec_pulse stays 0; release → inc_level=0 six edges after the falling input, no pulse.
2. Bounce rejection: increase_btn toggles with 3-cycle high / 1-cycle low pattern for 40 cycles, then 0 → inc_level and inc_pulse stay 0 throughout; then steady high → exactly one inc_pulse.
3. Simultaneous press: both buttons rise on the same edge, held 30 cycles → no pulses on either output, both levels 1. Release decrease only → no dec_pulse and no inc_pulse (repeat disabled).
4. Async reset mid-hold: increase held, rst_n pulled low for 3 ns between edges → all outputs 0 immediately. rst_n high with button still held → inc_pulse again 6 edges after reset release.
5. With PWM_BTN_AUTO_REPEAT_EN: hold increase 60 cycles after press pulse at cycle P → inc_pulse at P, P+20, P+28, P+36, P+44, P+52 only. Without macro → pulse at P only.
6. Invariant check, random button stimulus for 10000 cycles, both builds → inc_pulse&dec_pulse never 1; each pulse exactly 1 cycle wide.
